// File: rtl/gmi_mem_responder_pkg.sv
// Types and helpers shared by the GMI memory responder and its bench.
`include "gmi_defs.vh"

package gmi_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   typedef logic [1:0] rsp_status_t;

   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/gmi_mem_responder_if.sv
// GMI request/response bus between one initiator (master) and one responder (slave).
`include "gmi_defs.vh"

interface gmi_mem_responder_if #(
   parameter int DATA_WIDTH = `GMI_DATA_W,
   parameter int ADDR_WIDTH = `GMI_ADDR_W
) ();

   // valid/ready: a transfer happens on a rising edge where both are high;
   // once valid is raised its payload holds until that edge.
   logic                  gmi_req_valid;
   logic                  gmi_req_ready;
   logic                  gmi_req_write;
   logic [ADDR_WIDTH-1:0] gmi_req_addr;
   logic [DATA_WIDTH-1:0] gmi_req_wdata;
   logic                  gmi_rsp_valid;
   logic [1:0]            gmi_rsp_status;
   logic [DATA_WIDTH-1:0] gmi_rsp_rdata;
   logic                  gmi_rsp_ready;

   modport master (
      output gmi_req_valid, gmi_req_write, gmi_req_addr, gmi_req_wdata, gmi_rsp_ready,
      input  gmi_req_ready, gmi_rsp_valid, gmi_rsp_status, gmi_rsp_rdata
   );

   modport slave (
      input  gmi_req_valid, gmi_req_write, gmi_req_addr, gmi_req_wdata, gmi_rsp_ready,
      output gmi_req_ready, gmi_rsp_valid, gmi_rsp_status, gmi_rsp_rdata
   );

endinterface

// File: rtl/gmi_defs.vh
// Shared GMI bus definitions: default widths and response status encodings.
`ifndef GMI_DEFS_VH
`define GMI_DEFS_VH

`define GMI_DATA_W 32
`define GMI_ADDR_W 16

`define GMI_RSP_OKAY   2'b00
`define GMI_RSP_SLVERR 2'b10
`define GMI_RSP_DECERR 2'b11

`endif

// File: rtl/gmi_sp_ram.sv
// Single-port RAM: synchronous write, registered read, contents never reset.
module gmi_sp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int AW         = 8
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/gmi_mem_responder.sv
// GMI memory responder: one outstanding transaction, fixed response latency,
// DECERR for addresses at or beyond DEPTH.
`include "gmi_defs.vh"

module gmi_mem_responder
   import gmi_mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH = `GMI_DATA_W,
   parameter int ADDR_WIDTH = `GMI_ADDR_W,
   parameter int DEPTH      = 256,
   parameter int RSP_LAT    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   gmi_mem_responder_if.slave  bus,
   output logic                err_sticky,
   output state_t              dbg_state
);

   localparam int         RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT_LOAD = (RSP_LAT > 0) ? 4'(RSP_LAT - 1) : 4'd0;

   state_t                state;
   logic [3:0]            cnt;
   logic                  err_q;
   logic                  rd_ok_q;
   logic                  rsp_valid_q;
   rsp_status_t           rsp_status_q;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  accept;
   logic                  in_range;

   assign req_addr = bus.gmi_req_addr;
   assign accept   = bus.gmi_req_valid && (state == ST_IDLE);
   assign in_range = addr_in_range(32'(req_addr), 32'(DEPTH));

   // The RAM is only touched on an accepted in-range request, so its read
   // register holds the captured word for the whole transaction.
   gmi_sp_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (RAM_AW)
   ) u_ram (
      .clk  (clk),
      .en   (accept && in_range),
      .we   (bus.gmi_req_write),
      .addr (req_addr[RAM_AW-1:0]),
      .wdata(bus.gmi_req_wdata),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         err_q        <= 1'b0;
         rd_ok_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= `GMI_RSP_OKAY;
         err_sticky   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.gmi_req_valid) begin
                  err_q   <= !in_range;
                  rd_ok_q <= in_range && !bus.gmi_req_write;
                  if (RSP_LAT == 0) begin
                     state        <= ST_RSP;
                     rsp_valid_q  <= 1'b1;
                     rsp_status_q <= in_range ? `GMI_RSP_OKAY : `GMI_RSP_DECERR;
                     err_sticky   <= err_sticky | !in_range;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= LAT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state        <= ST_RSP;
                  rsp_valid_q  <= 1'b1;
                  rsp_status_q <= err_q ? `GMI_RSP_DECERR : `GMI_RSP_OKAY;
                  err_sticky   <= err_sticky | err_q;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RSP: begin
               if (bus.gmi_rsp_ready) begin
                  state        <= ST_IDLE;
                  rsp_valid_q  <= 1'b0;
                  rsp_status_q <= `GMI_RSP_OKAY;
                  rd_ok_q      <= 1'b0;
                  err_q        <= 1'b0;
               end
            end
            default: begin
               state        <= ST_IDLE;
               cnt          <= '0;
               rsp_valid_q  <= 1'b0;
               rsp_status_q <= `GMI_RSP_OKAY;
               rd_ok_q      <= 1'b0;
               err_q        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gmi_req_ready  = (state == ST_IDLE);
   assign bus.gmi_rsp_valid  = rsp_valid_q;
   assign bus.gmi_rsp_status = rsp_status_q;
   assign bus.gmi_rsp_rdata  = rd_ok_q ? ram_rdata : '0;
   assign dbg_state          = state;

endmodule
